fcr_master: RTL and testbench
=============================

Name: fcr_master

Overview:
Initiator end of the FPGA command-response byte link. It accepts one parallel 17-byte command frame: act, param, adr[47:0], data[71:0]. It serializes the frame MSB-first over the four-phase cmd_byte_req/cmd_byte_ack handshake. It then collects the 17-byte response over rsp_byte_req/rsp_byte_ack and presents it in parallel. It sits between a host-side controller (test sequencer, UART/USB bridge) and the command-response responder, and may cross clock domains.

Parameters:
TIMEOUT_CYCLES, 50000, clk cycles allowed in any single wait state before abort (timeout build only)
FRAME_BYTES, 17, bytes per frame in each direction; fixed by protocol, not user-changeable

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; latch cmd_* and begin transaction; ignored while busy
cmd_act  input  8  action byte (C_NOP/C_GET/C_SET)
cmd_param  input  8  parameter byte
cmd_adr  input  48  address
cmd_data  input  72  command data
busy  output  1  high from the cycle after accepted start until done
done  output  1  one-cycle completion pulse
bad_act  output  1  valid with done; command rejected locally, nothing transmitted
timeout  output  1  valid with done; handshake abandoned
rsp_err  output  1  response byte 0 bit 7
rsp_act  output  7  response byte 0 bits 6:0
rsp_param  output  8  response byte 1
rsp_adr  output  48  response bytes 2-7
rsp_data  output  72  response bytes 8-16
cmd_byte_req  output  1  link: command byte valid
cmd_byte_data  output  8  link: command byte
cmd_byte_ack  input  1  link: async, synchronized internally
rsp_byte_req  input  1  link: async, synchronized internally
rsp_byte_data  input  8  link: response byte, stable while rsp_byte_req high
rsp_byte_ack  output  1  link: response byte taken

Behaviour:
- Reset (rst high, any time, including mid-frame): all outputs 0; state S_IDLE; byte counter 0; rsp_* fields 0. No partial frame is resumed after reset.
- cmd_byte_ack and rsp_byte_req each pass through the two-flop sync module. All link decisions use the synchronized versions.
- Frame byte order, both directions: act, param, adr[47:40]..adr[7:0], data[71:64]..data[7:0]. Byte index counter runs 0..16.
- FSM:
  - S_IDLE: on start, latch inputs into a 136-bit shift register.
    - If cmd_act is not one of C_NOP/C_GET/C_SET: go to S_DONE with bad_act=1.
    - Otherwise go to S_CMD_REQ; busy=1.
  - S_CMD_REQ: drive cmd_byte_data = current byte; cmd_byte_req=1. When ack_s=1: cmd_byte_req=0, go to S_CMD_REL.
  - S_CMD_REL: wait for ack_s=0.
    - Index<16: shift, index+1, go to S_CMD_REQ.
    - Index=16: index=0, go to S_RSP_WAIT.
  - S_RSP_WAIT: when req_s=1, capture rsp_byte_data into byte slot[index], rsp_byte_ack=1, go to S_RSP_ACK.
  - S_RSP_ACK: when req_s=0, rsp_byte_ack=0.
    - Index<16: index+1, go to S_RSP_WAIT.
    - Index=16: go to S_DONE.
  - S_DONE: done=1 for exactly one cycle; busy=0 in that cycle; go to S_IDLE.
- cmd_byte_data is stable for the whole time cmd_byte_req is high. cmd_byte_req never re-rises until ack_s has been seen low.
- rsp_* outputs update only at S_DONE of a successful frame. They hold their previous value on bad_act or timeout.
- start coincident with S_DONE is ignored. bad_act and timeout are cleared at the next accepted start.
- Minimum throughput: about 4 + 2×(sync latency) cycles per byte; there is no fixed latency.

Optional Feature:
FCR_MST_TIMEOUT_EN
- Defined: a counter resets on every state change and increments in S_CMD_REQ, S_CMD_REL, S_RSP_WAIT and S_RSP_ACK. When it reaches TIMEOUT_CYCLES: drop cmd_byte_req and rsp_byte_ack, go to S_DONE with timeout=1. This covers the responder silently rejecting a frame.
- Undefined: no counter; timeout is tied to 0; wait states wait indefinitely, and only rst recovers the block.

Decomposition:
- Shared package (existing inc_params.v): C_NOP, C_GET, C_SET, C_VNUM, and FCR_FRAME_BYTES=17.
- FSM state encodings stay local to the module.
- Reuse the existing sync module, two instances. No new sub-module.

Test Plan:
- GET VNUM: start with act=C_GET, param=C_VNUM, adr=0, data=0; responder model has vnum=16'h0123 → exactly 17 cmd_byte_req pulses; done with rsp_err=0, rsp_data=72'h0123, bad_act=0, timeout=0.
- Byte order: SET with adr=48'h010203040506, data=72'h0A0B0C0D0E0F101112 → monitor captures bytes 02,param,01..06,0A..12 in order. rsp_adr equals the echoed value.
- Bad action: act=8'hFF → done within 2 cycles with bad_act=1; cmd_byte_req never asserts; rsp_* unchanged.
- Timeout (macro defined, TIMEOUT_CYCLES=100): responder never acks → cmd_byte_req drops; done with timeout=1 about 100 cycles after the request.
- Reset mid-frame: assert rst after the 5th command byte ack → cmd_byte_req, busy and rsp_byte_ack go 0 immediately. The next start sends a full 17-byte frame from byte 0.
- Start while busy: second start pulse during S_RSP_WAIT → ignored; the first frame completes unaltered and done pulses exactly once.

Source files
------------

// File: rtl/fcr_master_pkg.sv
// Shared constants for the FPGA command-response byte link.
// Action codes, parameter codes and the fixed frame size live here so the
// initiator and its testbench agree on one definition.
package fcr_master_pkg;

  localparam int FCR_FRAME_BYTES = 17;
  localparam int FCR_FRAME_BITS  = FCR_FRAME_BYTES * 8;

  localparam logic [7:0] C_NOP  = 8'h00;
  localparam logic [7:0] C_GET  = 8'h01;
  localparam logic [7:0] C_SET  = 8'h02;
  localparam logic [7:0] C_VNUM = 8'h01;

  // Only NOP, GET and SET are ever put on the link.
  function automatic logic act_is_valid(input logic [7:0] act);
    return (act == C_NOP) || (act == C_GET) || (act == C_SET);
  endfunction

endpackage

// File: rtl/fcr_master_sync.sv
// Two-flop synchronizer for a single asynchronous level from the link.
module fcr_master_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; only sync_q is used downstream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fcr_master.sv
// Initiator end of the command-response byte link.
// Serializes a 17-byte command frame MSB-first over a four-phase req/ack
// handshake, then collects the 17-byte response and presents it in parallel.
// Optional build macro FCR_MST_TIMEOUT_EN adds a per-wait-state abort counter.
//
// Handshake: cmd_byte_req_o rises with cmd_byte_data_o already stable, stays
// high until the synchronized ack is seen, and never re-rises until that ack
// has been seen low again. rsp_byte_ack_o rises after rsp_byte_data_i has been
// captured and falls once the synchronized rsp_byte_req_i is seen low.
module fcr_master
  import fcr_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
)
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [7:0]   cmd_act_i,
  input  logic [7:0]   cmd_param_i,
  input  logic [47:0]  cmd_adr_i,
  input  logic [71:0]  cmd_data_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         bad_act_o,
  output logic         timeout_o,
  output logic         rsp_err_o,
  output logic [6:0]   rsp_act_o,
  output logic [7:0]   rsp_param_o,
  output logic [47:0]  rsp_adr_o,
  output logic [71:0]  rsp_data_o,
  output logic         cmd_byte_req_o,
  output logic [7:0]   cmd_byte_data_o,
  input  logic         cmd_byte_ack_i,
  input  logic         rsp_byte_req_i,
  input  logic [7:0]   rsp_byte_data_i,
  output logic         rsp_byte_ack_o,
  output logic [2:0]   dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CMD_REQ  = 3'd1,
    S_CMD_REL  = 3'd2,
    S_RSP_WAIT = 3'd3,
    S_RSP_ACK  = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  localparam logic [4:0] LAST_IDX = 5'(FCR_FRAME_BYTES - 1);

  state_e                      state_q, state_d;
  logic [FCR_FRAME_BITS-1:0]   cmd_sh_q;
  logic [FCR_FRAME_BITS-1:0]   rsp_sh_q;
  logic [FCR_FRAME_BITS-1:0]   rsp_q;
  logic [4:0]                  idx_q;
  logic                        bad_act_q;
  logic                        timeout_q;
  logic                        ack_s;
  logic                        req_s;
  logic                        in_wait;
  logic                        tmo_hit;

  fcr_master_sync u_sync_ack (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (cmd_byte_ack_i),
    .q_o   (ack_s)
  );

  fcr_master_sync u_sync_req (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rsp_byte_req_i),
    .q_o   (req_s)
  );

  assign in_wait = (state_q == S_CMD_REQ) || (state_q == S_CMD_REL) ||
                   (state_q == S_RSP_WAIT) || (state_q == S_RSP_ACK);

`ifdef FCR_MST_TIMEOUT_EN
  logic [31:0] tmo_q;

  // Cycles spent in the current wait state; restarts on any state change.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_q <= '0;
    end else if (state_d != state_q) begin
      tmo_q <= '0;
    end else if (in_wait) begin
      tmo_q <= tmo_q + 32'd1;
    end
  end

  assign tmo_hit = in_wait && (tmo_q >= 32'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a timeout overrides every wait state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start_i) state_d = act_is_valid(cmd_act_i) ? S_CMD_REQ : S_DONE;
      S_CMD_REQ:  if (ack_s) state_d = S_CMD_REL;
      S_CMD_REL:  if (!ack_s) state_d = (idx_q == LAST_IDX) ? S_RSP_WAIT : S_CMD_REQ;
      S_RSP_WAIT: if (req_s) state_d = S_RSP_ACK;
      S_RSP_ACK:  if (!req_s) state_d = (idx_q == LAST_IDX) ? S_DONE : S_RSP_WAIT;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (tmo_hit) state_d = S_DONE;
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    busy_o         = in_wait;
    done_o         = (state_q == S_DONE);
    cmd_byte_req_o = (state_q == S_CMD_REQ);
    rsp_byte_ack_o = (state_q == S_RSP_ACK);
  end

  // Frame datapath: command shift-out, response shift-in, status flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmd_sh_q  <= '0;
      rsp_sh_q  <= '0;
      rsp_q     <= '0;
      idx_q     <= '0;
      bad_act_q <= 1'b0;
      timeout_q <= 1'b0;
    end else if (tmo_hit) begin
      timeout_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            cmd_sh_q  <= {cmd_act_i, cmd_param_i, cmd_adr_i, cmd_data_i};
            idx_q     <= '0;
            bad_act_q <= !act_is_valid(cmd_act_i);
            timeout_q <= 1'b0;
          end
        end
        S_CMD_REL: begin
          if (!ack_s) begin
            if (idx_q == LAST_IDX) begin
              idx_q <= '0;
            end else begin
              idx_q    <= idx_q + 5'd1;
              cmd_sh_q <= {cmd_sh_q[FCR_FRAME_BITS-9:0], 8'h00};
            end
          end
        end
        S_RSP_WAIT: begin
          if (req_s) rsp_sh_q <= {rsp_sh_q[FCR_FRAME_BITS-9:0], rsp_byte_data_i};
        end
        S_RSP_ACK: begin
          if (!req_s) begin
            if (idx_q == LAST_IDX) rsp_q <= rsp_sh_q;
            else                   idx_q <= idx_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_byte_data_o = cmd_sh_q[FCR_FRAME_BITS-1 -: 8];
  assign bad_act_o       = bad_act_q;
  assign timeout_o       = timeout_q;
  assign rsp_err_o       = rsp_q[135];
  assign rsp_act_o       = rsp_q[134:128];
  assign rsp_param_o     = rsp_q[127:120];
  assign rsp_adr_o       = rsp_q[119:72];
  assign rsp_data_o      = rsp_q[71:0];
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_fcr_master.sv
// Testbench for fcr_master: a link responder model answers each command
// frame; expected byte streams and responses come from a frame-level model.
module tb_fcr_master;
  import fcr_master_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start;
  logic [7:0]   cmd_act, cmd_param;
  logic [47:0]  cmd_adr;
  logic [71:0]  cmd_data;
  logic         busy, done, bad_act, timeout;
  logic         rsp_err;
  logic [6:0]   rsp_act;
  logic [7:0]   rsp_param;
  logic [47:0]  rsp_adr;
  logic [71:0]  rsp_data;
  logic         cmd_byte_req;
  logic [7:0]   cmd_byte_data;
  logic         cmd_byte_ack;
  logic         rsp_byte_req;
  logic [7:0]   rsp_byte_data;
  logic         rsp_byte_ack;
  logic [2:0]   dbg_state;

  fcr_master #(.TIMEOUT_CYCLES(100)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .cmd_act_i       (cmd_act),
    .cmd_param_i     (cmd_param),
    .cmd_adr_i       (cmd_adr),
    .cmd_data_i      (cmd_data),
    .busy_o          (busy),
    .done_o          (done),
    .bad_act_o       (bad_act),
    .timeout_o       (timeout),
    .rsp_err_o       (rsp_err),
    .rsp_act_o       (rsp_act),
    .rsp_param_o     (rsp_param),
    .rsp_adr_o       (rsp_adr),
    .rsp_data_o      (rsp_data),
    .cmd_byte_req_o  (cmd_byte_req),
    .cmd_byte_data_o (cmd_byte_data),
    .cmd_byte_ack_i  (cmd_byte_ack),
    .rsp_byte_req_i  (rsp_byte_req),
    .rsp_byte_data_i (rsp_byte_data),
    .rsp_byte_ack_o  (rsp_byte_ack),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]   exp_q[$];
  logic [7:0]   mon_q[$];
  logic [135:0] model_rsp = '0;
  logic [135:0] cur_frame;
  logic         cur_valid;
  int           done_cnt = 0;
  int           done_base;
  logic         resp_on = 1'b1;
  int           r_phase = 0;

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // What the responder sends back for a given command frame.
  function automatic logic [135:0] reply(input logic [135:0] f);
    logic [7:0]  a, p;
    logic [47:0] ad;
    logic [71:0] d, rd;
    {a, p, ad, d} = f;
    if (a == C_GET && p == C_VNUM) rd = 72'h0123;
    else if (a == C_SET)           rd = d;
    else                           rd = '0;
    return {(p == 8'hEE), a[6:0], p, ad, rd};
  endfunction

  function automatic logic [135:0] obs_rsp();
    return {rsp_err, rsp_act, rsp_param, rsp_adr, rsp_data};
  endfunction

  // Count done pulses just after each active edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (done) done_cnt++;
  end

  // ---------------- link responder ----------------
  initial begin
    int           r_cnt;
    int           r_wait;
    logic [135:0] cap;
    logic [7:0]   rbytes[17];
    r_cnt = 0; r_wait = 0; cap = '0;
    cmd_byte_ack = 1'b0; rsp_byte_req = 1'b0; rsp_byte_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        r_phase = 0; r_cnt = 0; r_wait = 0;
        cmd_byte_ack = 1'b0; rsp_byte_req = 1'b0;
      end else if (r_wait > 0) begin
        r_wait--;
        if (r_phase == 1 && cmd_byte_req) check("cmd_data_stable", 136'(cmd_byte_data), 136'(mon_q[$]));
      end else begin
        case (r_phase)
          0: if (cmd_byte_req && resp_on) begin
               mon_q.push_back(cmd_byte_data);
               cap = {cap[127:0], cmd_byte_data};
               cmd_byte_ack = 1'b1;
               r_phase = 1;
               r_wait = $urandom_range(0, 3);
             end
          1: if (!cmd_byte_req) begin
               cmd_byte_ack = 1'b0;
               r_cnt++;
               r_wait = $urandom_range(0, 3);
               if (r_cnt == 17) begin
                 for (int i = 0; i < 17; i++) rbytes[i] = reply(cap)[135-8*i -: 8];
                 r_cnt = 0;
                 r_phase = 2;
               end else begin
                 r_phase = 0;
               end
             end else begin
               check("cmd_data_stable", 136'(cmd_byte_data), 136'(mon_q[$]));
             end
          2: begin
               rsp_byte_data = rbytes[r_cnt];
               rsp_byte_req = 1'b1;
               r_phase = 3;
             end
          3: if (rsp_byte_ack) begin
               rsp_byte_req = 1'b0;
               r_phase = 4;
               r_wait = $urandom_range(0, 3);
             end
          4: if (!rsp_byte_ack) begin
               r_cnt++;
               r_wait = $urandom_range(0, 3);
               if (r_cnt == 17) begin r_cnt = 0; r_phase = 0; end
               else r_phase = 2;
             end
          default: r_phase = 0;
        endcase
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic launch(input logic [7:0] a, input logic [7:0] p,
                        input logic [47:0] ad, input logic [71:0] d);
    @(negedge clk);
    cur_frame = {a, p, ad, d};
    cur_valid = (a == C_NOP) || (a == C_GET) || (a == C_SET);
    exp_q.delete();
    mon_q.delete();
    if (cur_valid) for (int i = 0; i < 17; i++) exp_q.push_back(cur_frame[135-8*i -: 8]);
    done_base = done_cnt;
    cmd_act = a; cmd_param = p; cmd_adr = ad; cmd_data = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs: the frame must have been latched at start.
    cmd_act = 8'($urandom); cmd_param = 8'($urandom);
    cmd_adr = {16'($urandom), 32'($urandom)};
    cmd_data = {8'($urandom), 32'($urandom), 32'($urandom)};
  endtask

  task automatic finish_txn(input string tag, input logic exp_tmo, output int cycles);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    cycles = n;
    check({tag, "_done_seen"}, 136'(done), 136'(1));
    if (cur_valid && !exp_tmo) model_rsp = reply(cur_frame);
    check({tag, "_bad_act"}, 136'(bad_act), 136'(!cur_valid));
    check({tag, "_timeout"}, 136'(timeout), 136'(exp_tmo));
    check({tag, "_busy_at_done"}, 136'(busy), 136'(0));
    check({tag, "_rsp"}, obs_rsp(), model_rsp);
    check({tag, "_nbytes"}, 136'(mon_q.size()), 136'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
      check({tag, "_byte"}, 136'(mon_q[i]), 136'(exp_q[i]));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 136'(done), 136'(0));
    check({tag, "_done_count"}, 136'(done_cnt - done_base), 136'(1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    int n;
    logic [7:0] ra;
    logic [7:0] rp;
    rst = 1'b1; start = 1'b0;
    cmd_act = '0; cmd_param = '0; cmd_adr = '0; cmd_data = '0;
    repeat (4) @(negedge clk);
    check("reset_ctrl", 136'({busy, done, bad_act, timeout, cmd_byte_req, rsp_byte_ack}), 136'(0));
    check("reset_rsp", obs_rsp(), 136'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // GET VNUM
    launch(C_GET, C_VNUM, 48'h0, 72'h0);
    check("get_busy", 136'(busy), 136'(1));
    finish_txn("get_vnum", 1'b0, cyc);
    check("get_vnum_data", 136'(rsp_data), 136'(72'h0123));
    check("get_vnum_err", 136'(rsp_err), 136'(0));

    // SET byte order
    launch(C_SET, 8'h5A, 48'h010203040506, 72'h0A0B0C0D0E0F101112);
    finish_txn("set_order", 1'b0, cyc);
    if (mon_q.size() == 17) begin
      check("set_first", 136'(mon_q[0]), 136'(8'h02));
      check("set_adr_hi", 136'(mon_q[2]), 136'(8'h01));
      check("set_last", 136'(mon_q[16]), 136'(8'h12));
    end
    check("set_rsp_adr", 136'(rsp_adr), 136'(48'h010203040506));

    // Bad action
    launch(8'hFF, 8'h00, 48'h1, 72'h1);
    finish_txn("bad_act", 1'b0, cyc);
    check("bad_act_fast", 136'(cyc <= 2), 136'(1));

    // Random frames
    for (int k = 0; k < 10; k++) begin
      case ($urandom_range(0, 3))
        0: ra = C_NOP;
        1: ra = C_GET;
        2: ra = C_SET;
        default: ra = 8'($urandom);
      endcase
      case ($urandom_range(0, 2))
        0: rp = C_VNUM;
        1: rp = 8'hEE;
        default: rp = 8'($urandom);
      endcase
      launch(ra, rp, {16'($urandom), 32'($urandom)}, {8'($urandom), 32'($urandom), 32'($urandom)});
      finish_txn("random", 1'b0, cyc);
    end

    // Start while busy
    launch(C_SET, 8'h33, 48'hA1A2A3A4A5A6, 72'h112233445566778899);
    n = 0;
    while (r_phase < 2 && n < 2000) begin @(negedge clk); n++; end
    check("busy_wait_rsp_phase", 136'(r_phase >= 2), 136'(1));
    cmd_act = C_GET; cmd_param = C_VNUM; cmd_adr = '0; cmd_data = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_txn("start_busy", 1'b0, cyc);
    repeat (20) @(negedge clk);
    check("start_busy_idle", 136'({busy, cmd_byte_req}), 136'(0));
    check("start_busy_no_extra_done", 136'(done_cnt - done_base), 136'(1));

    // Reset mid-frame after the 5th command byte ack
    launch(C_SET, 8'h44, 48'hBEEF, 72'hCAFE);
    n = 0;
    while (!(mon_q.size() == 5 && cmd_byte_ack) && n < 2000) begin @(negedge clk); n++; end
    check("rst_mid_reached", 136'(mon_q.size()), 136'(5));
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", 136'({cmd_byte_req, busy, rsp_byte_ack, done}), 136'(0));
    model_rsp = '0;
    check("rst_mid_rsp_cleared", obs_rsp(), model_rsp);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    launch(C_GET, 8'h07, 48'h123456789ABC, 72'h0);
    finish_txn("after_rst", 1'b0, cyc);

`ifdef FCR_MST_TIMEOUT_EN
    resp_on = 1'b0;
    launch(C_GET, C_VNUM, 48'h0, 72'h0);
    exp_q.delete();
    check("tmo_req_high", 136'(cmd_byte_req), 136'(1));
    finish_txn("timeout", 1'b1, cyc);
    check("tmo_window", 136'(cyc >= 90 && cyc <= 110), 136'(1));
    check("tmo_req_dropped", 136'(cmd_byte_req), 136'(0));
    resp_on = 1'b1;
    launch(C_SET, 8'h21, 48'h777, 72'h888);
    finish_txn("after_tmo", 1'b0, cyc);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
